// File: rtl/bcd_countdown_timer_if.sv
// rtl/bcd_countdown_timer_if.sv - control/display bus between the front-panel stage and the countdown timer
interface bcd_countdown_timer_if;
    logic [3:0]  state;
    logic [23:0] loadBits;
    logic [23:0] currentBits;
    logic        tickPulse;
    logic        running;
    logic        alarm;

    modport master (
        output state,
        output loadBits,
        input  currentBits,
        input  tickPulse,
        input  running,
        input  alarm
    );

    modport slave (
        input  state,
        input  loadBits,
        output currentBits,
        output tickPulse,
        output running,
        output alarm
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - BCD hh:mm:ss countdown with one-second prescaler and sticky zero alarm
module bcd_countdown_timer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                      clk,
    input  logic                      resetN,
    bcd_countdown_timer_if.slave      bus
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST_COUNT = PW'(TICK_DIV - 1);
    localparam logic [23:0] RESET_TIME = 24'h125959;

    typedef enum logic [1:0] {
        MODE_LOAD,
        MODE_RUN,
        MODE_HOLD
    } mode_t;

    mode_t          mode;
    logic [PW-1:0]  prescaler;
    logic [23:0]    currentReg;
    logic           tickReg;
    logic           runningReg;
    logic           alarmReg;
    logic [23:0]    clampedLoad;
    logic [23:0]    nextTime;
    logic           tickDue;

    // Digit limits first, then the 12-hour ceiling on the combined hour value.
    function automatic logic [23:0] clampTime(input logic [23:0] t);
        logic [3:0] ht, hu, mt, mu, st, su;
        ht = (t[23:20] > 4'd1) ? 4'd1 : t[23:20];
        hu = (t[19:16] > 4'd9) ? 4'd9 : t[19:16];
        mt = (t[15:12] > 4'd5) ? 4'd5 : t[15:12];
        mu = (t[11:8]  > 4'd9) ? 4'd9 : t[11:8];
        st = (t[7:4]   > 4'd5) ? 4'd5 : t[7:4];
        su = (t[3:0]   > 4'd9) ? 4'd9 : t[3:0];
        if (ht == 4'd1 && hu > 4'd2) begin
            hu = 4'd2;
        end
        return {ht, hu, mt, mu, st, su};
    endfunction

    // One-second BCD decrement; only called with a non-zero value so hours never underflow.
    function automatic logic [23:0] decrementTime(input logic [23:0] t);
        logic [3:0] ht, hu, mt, mu, st, su;
        {ht, hu, mt, mu, st, su} = t;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    if (mt != 4'd0) begin
                        mt = mt - 4'd1;
                    end else begin
                        mt = 4'd5;
                        if (hu != 4'd0) begin
                            hu = hu - 4'd1;
                        end else begin
                            hu = 4'd9;
                            ht = ht - 4'd1;
                        end
                    end
                end
            end
        end
        return {ht, hu, mt, mu, st, su};
    endfunction

    always_comb begin
        mode = MODE_HOLD;
        case (bus.state)
            4'd0, 4'd1: mode = MODE_LOAD;
            4'd3:       mode = MODE_RUN;
            default:    mode = MODE_HOLD;
        endcase
    end

    assign clampedLoad = clampTime(bus.loadBits);
    assign nextTime    = decrementTime(currentReg);
    assign tickDue     = (prescaler == LAST_COUNT);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            currentReg <= RESET_TIME;
            prescaler  <= '0;
            tickReg    <= 1'b0;
            runningReg <= 1'b0;
            alarmReg   <= 1'b0;
        end else begin
            tickReg <= 1'b0;
            case (mode)
                MODE_LOAD: begin
                    currentReg <= clampedLoad;
                    prescaler  <= '0;
                    alarmReg   <= 1'b0;
                    runningReg <= 1'b0;
                end
                MODE_RUN: begin
                    if (alarmReg) begin
                        runningReg <= 1'b0;
                    end else if (!tickDue) begin
                        prescaler  <= prescaler + 1'b1;
                        runningReg <= 1'b1;
                    end else begin
                        prescaler <= '0;
                        if (currentReg == 24'h000000) begin
                            alarmReg   <= 1'b1;
                            runningReg <= 1'b0;
                        end else begin
                            currentReg <= nextTime;
                            tickReg    <= 1'b1;
                            alarmReg   <= (nextTime == 24'h000000);
                            runningReg <= (nextTime != 24'h000000);
                        end
                    end
                end
                default: begin
                    runningReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.currentBits = currentReg;
    assign bus.tickPulse   = tickReg;
    assign bus.running     = runningReg;
    assign bus.alarm       = alarmReg;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed self-checking bench for bcd_countdown_timer
module tb_bcd_countdown_timer;

    logic clk;
    logic resetN;
    int   assertCount;
    int   failCount;

    bcd_countdown_timer_if bus ();

    bcd_countdown_timer #(.TICK_DIV(4)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [23:0] observed, input logic [23:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: observed %06h expected %06h", tag, observed, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [23:0] t, input logic r, input logic a, input logic p);
        checkVal({tag, ".time"},    bus.currentBits, t);
        checkVal({tag, ".running"}, {23'd0, bus.running}, {23'd0, r});
        checkVal({tag, ".alarm"},   {23'd0, bus.alarm},   {23'd0, a});
        checkVal({tag, ".tick"},    {23'd0, bus.tickPulse}, {23'd0, p});
    endtask

    task automatic loadTime(input logic [23:0] t);
        bus.state    = 4'd1;
        bus.loadBits = t;
        cycles(1);
    endtask

    initial begin
        assertCount  = 0;
        failCount    = 0;
        resetN       = 1'b1;
        bus.state    = 4'd2;
        bus.loadBits = 24'h000000;

        #3 resetN = 1'b0;
        #1;
        checkAll("reset", 24'h125959, 1'b0, 1'b0, 1'b0);
        #3 resetN = 1'b1;
        cycles(1);
        checkAll("holdAfterReset", 24'h125959, 1'b0, 1'b0, 1'b0);

        loadTime(24'h010001);
        checkAll("load", 24'h010001, 1'b0, 1'b0, 1'b0);
        bus.state = 4'd3;
        cycles(1);
        checkAll("run1", 24'h010001, 1'b1, 1'b0, 1'b0);
        cycles(2);
        checkAll("run3", 24'h010001, 1'b1, 1'b0, 1'b0);
        cycles(1);
        checkAll("tick1", 24'h010000, 1'b1, 1'b0, 1'b1);
        cycles(1);
        checkAll("tick1End", 24'h010000, 1'b1, 1'b0, 1'b0);
        cycles(3);
        checkAll("borrowHour", 24'h005959, 1'b1, 1'b0, 1'b1);

        loadTime(24'h100000);
        bus.state = 4'd3;
        cycles(4);
        checkAll("hourTens", 24'h095959, 1'b1, 1'b0, 1'b1);

        loadTime(24'h000002);
        bus.state = 4'd3;
        cycles(2);
        checkAll("prePause", 24'h000002, 1'b1, 1'b0, 1'b0);
        bus.state = 4'd2;
        cycles(10);
        checkAll("paused", 24'h000002, 1'b0, 1'b0, 1'b0);
        bus.state = 4'd3;
        cycles(1);
        checkAll("resume1", 24'h000002, 1'b1, 1'b0, 1'b0);
        cycles(1);
        checkAll("resumeTick", 24'h000001, 1'b1, 1'b0, 1'b1);
        bus.state = 4'd9;
        cycles(3);
        checkAll("exceptionHold", 24'h000001, 1'b0, 1'b0, 1'b0);
        bus.state = 4'd3;
        cycles(4);
        checkAll("reachZero", 24'h000000, 1'b0, 1'b1, 1'b1);
        cycles(12);
        checkAll("stayZero", 24'h000000, 1'b0, 1'b1, 1'b0);

        loadTime(24'h000010);
        checkAll("alarmClear", 24'h000010, 1'b0, 1'b0, 1'b0);
        bus.state = 4'd3;
        cycles(4);
        checkAll("afterClear", 24'h000009, 1'b1, 1'b0, 1'b1);

        loadTime(24'h000000);
        bus.state = 4'd3;
        cycles(3);
        checkAll("zeroStartRun", 24'h000000, 1'b1, 1'b0, 1'b0);
        cycles(1);
        checkAll("zeroStartTick", 24'h000000, 1'b0, 1'b1, 1'b0);

        loadTime(24'h1F7A6C);
        checkVal("clampAll", bus.currentBits, 24'h125959);
        loadTime(24'h2A0000);
        checkVal("clampHour", bus.currentBits, 24'h120000);
        loadTime(24'h095A7F);
        checkVal("clampMinSec", bus.currentBits, 24'h095959);

        loadTime(24'h000500);
        bus.state = 4'd3;
        cycles(4);
        checkAll("preAsync", 24'h000459, 1'b1, 1'b0, 1'b1);
        #2 resetN = 1'b0;
        #1;
        checkAll("asyncReset", 24'h125959, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
        cycles(1);
        checkAll("afterRelease", 24'h125959, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Downstream timekeeping stage of the patient-medication clock. Takes the 24-bit BCD `hh mm ss` value and the 4-bit `state` code produced by the front-panel control stage, then loads, holds, or counts down that value once per second. Its `currentBits` output feeds back to the control stage and to the seven-segment display driver. It raises a sticky `alarm` when the countdown reaches 00:00:00.

## Interface
- `TICK_DIV`, 50_000_000: number of `clk` cycles per one-second tick; must be ≥ 2.
- `clk`  in  1: system clock; all flops use the rising edge.
- `resetN`  in  1: asynchronous, active-low reset.
- `state`  in  4: control code. 0 = reset, 1 = set, 2 = load patient ID, 3 = start; 4–15 are exception codes.
- `loadBits`  in  24: BCD time from the control stage, `[23:20]` hour tens through `[3:0]` second units.
- `currentBits`  out  24: registered BCD time remaining.
- `tickPulse`  out  1: registered; high for exactly one cycle after each decrement.
- `running`  out  1: registered; high while counting down.
- `alarm`  out  1: registered, sticky; high once the countdown has reached zero.

## Operation
- **Reset** (`resetN` = 0, asynchronous):
  - `currentBits` = 24'h125959
  - prescaler = 0
  - `tickPulse`, `running` and `alarm` = 0
- **Load**, `state` 0 or 1, evaluated every cycle:
  - `currentBits` takes the clamped `loadBits`.
  - prescaler = 0; `alarm` = 0; `running` = 0; `tickPulse` = 0.
- **Clamp rules**, applied in this order:
  - Second units and minute units greater than 9 become 9.
  - Second tens and minute tens greater than 5 become 5.
  - Hour tens greater than 1 becomes 1; hour units greater than 9 becomes 9.
  - If the resulting hours exceed 12, hours become 12.
- **Hold**, `state` 2 or 4–15:
  - `currentBits`, prescaler and `alarm` are all frozen.
  - `running` = 0; `tickPulse` = 0.
- **Run**, `state` 3 with `alarm` = 0:
  - `running` = 1 and the prescaler increments every cycle.
  - When the prescaler equals `TICK_DIV`-1, it wraps to 0 and a tick is performed.
- **Tick, normal case**, `currentBits` ≠ 0:
  - The value decrements by one second with BCD borrow: ss 00 → 59 borrows a minute; mm 00 → 59 borrows an hour.
  - Hours decrement as the 2-digit BCD value 12..00; units 0 → 9 borrows from tens.
  - `tickPulse` is high in the next cycle.
  - If the new value is 24'h000000, `alarm` = 1 and `running` = 0 on the same edge.
- **Tick with the value already zero** (started at 00:00:00): no decrement, `alarm` = 1, `running` = 0, `tickPulse` = 0.
- **Run with `alarm` = 1:**
  - The value is held and the prescaler is frozen.
  - `running` = 0; `tickPulse` = 0.
  - `alarm` clears only through the Load path or `resetN`.
- All arithmetic stays digit-wise BCD; no binary intermediate value ever appears on `currentBits`.

## Timing
- Load latency is 1 cycle: `loadBits` sampled at edge N appears on `currentBits` after edge N.
- `state` is sampled every edge with no handshake; a single cycle of `state` 1 is enough to load.
- First tick: with the prescaler at 0, the decrement lands on the `TICK_DIV`-th consecutive state-3 edge. Later ticks follow every `TICK_DIV` edges.
- Pause and resume: time spent in Hold does not count. The prescaler resumes from its frozen value, so the total state-3 edges between ticks stays `TICK_DIV`.
- `tickPulse` is asserted in the cycle after the edge that changed `currentBits`.
- `running` goes to 1 on the first state-3 edge; the reset-to-first-assert latency is 1 cycle.
- Asynchronous reset mid-run takes effect immediately, with no dependence on `clk`. The first edge after release behaves normally according to `state`.

## Test plan
- **Reset:** hold `resetN` low mid-count → `currentBits`=125959, `alarm`=0, `running`=0, `tickPulse`=0 with no clock edge required.
- **Load and borrow** (`TICK_DIV`=4): `state`=1 with `loadBits`=010001, then `state`=3.
  - After 4 edges: 010000 and one `tickPulse`.
  - After 4 more: 005959.
- **Countdown to zero** (`TICK_DIV`=4): load 000002, then run.
  - Ticks produce 000001, then 000000 with `alarm`=1 and `running`=0.
  - 12 further edges → value, `alarm` and `tickPulse` remain 000000, 1, 0.
- **Pause:** run for 2 edges, `state`=2 for 10 edges, then `state`=3 → the first decrement occurs after 2 more state-3 edges.
- **Clamp:** load 1F7A6C → `currentBits`=125959; load 2A0000 → 120000.
- **Alarm clear:** after the alarm, `state`=1 with 000010 → `alarm`=0 next cycle; `state`=3 resumes counting.
